// File: rtl/chao_trig_ctrl_if.sv
// Sensor-side signal bundle for the ultrasonic trigger/echo sequencer.
// Latency: none (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
//
// Signals:
//   enable    - level, 1 = run measurements continuously (driver -> controller)
//   echo      - raw sensor echo, asynchronous to clk       (driver -> controller)
//   trig      - registered sensor trigger                   (controller -> driver)
//   echo_sync - echo after the 2-FF synchroniser            (controller -> driver)
//   busy      - 1 whenever the sequencer is not idle        (controller -> driver)
//   meas_done - 1-cycle pulse on a valid echo falling edge  (controller -> driver)
//   timeout   - 1-cycle pulse on rise or echo-high timeout  (controller -> driver)
interface chao_trig_ctrl_if;
  logic enable;
  logic echo;
  logic trig;
  logic echo_sync;
  logic busy;
  logic meas_done;
  logic timeout;

  // master: whoever drives enable/echo and consumes the status (bench or sensor wrapper)
  modport master (
    output enable,
    output echo,
    input  trig,
    input  echo_sync,
    input  busy,
    input  meas_done,
    input  timeout
  );

  // slave: the trigger/echo sequencer itself
  modport slave (
    input  enable,
    input  echo,
    output trig,
    output echo_sync,
    output busy,
    output meas_done,
    output timeout
  );
endinterface

// File: rtl/chao_trig_ctrl.sv
// Ultrasonic ranging sequencer: periodic trig pulse, echo synchroniser, phase FSM.
// Latency: all outputs registered; echo_sync lags echo by 2 cycles, meas_done by 3.
// Backpressure: none; measurements free-run at PERIOD_CYCLES spacing while enable=1.
//
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   bus   - chao_trig_ctrl_if.slave: enable/echo in; trig, echo_sync, busy,
//           meas_done, timeout out
module chao_trig_ctrl #(
  parameter int unsigned TRIG_CYCLES   = 500,
  parameter int unsigned RISE_TIMEOUT  = 1_500_000,
  parameter int unsigned ECHO_MAX      = 1_250_000,
  parameter int unsigned PERIOD_CYCLES = 3_000_000,
  parameter int unsigned CNT_W         = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  chao_trig_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    WAIT_FALL = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  // Terminal counts: each phase ends on the cycle its counter reaches N-1.
  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST   = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST   = CNT_W'(ECHO_MAX - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;   // cycles spent in the current phase
  logic [CNT_W-1:0] pcnt_q, pcnt_d;   // cycles since the last trig rising edge
  logic             s1_q, s2_q, s3_q; // echo synchroniser + edge-detect stage
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;
  logic             rise, fall;

  // s1/s2 form the synchroniser proper; s3 only delays s2 for edge detection,
  // so nothing downstream of echo is combinational.
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // Next-state and pulse decode. Edge checks come before limit checks so a
  // real edge landing on the last allowed cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = TRIG;
      end
      TRIG: begin
        // echo edges are deliberately ignored while the sensor is being fired
        if (ccnt_q == TRIG_LAST) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        // only a rise edge counts: an echo already high on entry is stale
        if (rise) begin
          state_d = WAIT_FALL;
        end else if (ccnt_q == RISE_LAST) begin
          tout_d  = 1'b1;
          state_d = HOLDOFF;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          done_d  = 1'b1;
          state_d = HOLDOFF;
        end else if (ccnt_q == ECHO_LAST) begin
          tout_d  = 1'b1;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        // >= lets a measurement that already used up the period leave at once
        if (pcnt_q >= PERIOD_LAST) state_d = bus.enable ? TRIG : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counters and registered outputs derived from the next state, so trig and
  // busy line up exactly with the state they describe.
  always_comb begin
    ccnt_d = (state_d != state_q) ? '0
           : (&ccnt_q)            ? ccnt_q
           :                        ccnt_q + CNT_W'(1);
    // pcnt restarts on every TRIG entry (including HOLDOFF -> TRIG) and
    // saturates so a long idle stretch never wraps it.
    pcnt_d = (state_d == TRIG && state_q != TRIG) ? '0
           : (&pcnt_q)                            ? pcnt_q
           :                                        pcnt_q + CNT_W'(1);
    trig_d = (state_d == TRIG);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ccnt_q  <= '0;
      pcnt_q  <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
      pcnt_q  <= pcnt_d;
      s1_q    <= bus.echo;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.trig      = trig_q;
  assign bus.echo_sync = s2_q;
  assign bus.busy      = busy_q;
  assign bus.meas_done = done_q;
  assign bus.timeout   = tout_q;

endmodule

// File: tb/tb_chao_trig_ctrl.sv
// Scoreboard bench for chao_trig_ctrl with short bench timing parameters.
// Stimulus pushes hand-computed (event, cycle) expectations; a negedge monitor
// pops and compares on every output edge/pulse and at snapshot cycles.
module tb_chao_trig_ctrl;
  localparam int TRIG_C = 4;
  localparam int RISE_T = 20;
  localparam int ECHO_M = 50;
  localparam int PER    = 100;
  localparam int LIMIT  = 3000;

  localparam int K_SNAP   = 0;
  localparam int K_BUSY_R = 1;
  localparam int K_TRIG_R = 2;
  localparam int K_TRIG_F = 3;
  localparam int K_ES_R   = 4;
  localparam int K_ES_F   = 5;
  localparam int K_DONE   = 6;
  localparam int K_TOUT   = 7;
  localparam int K_BUSY_F = 8;

  typedef struct {
    int         kind;
    int         cyc;
    logic [4:0] val;   // snapshot {trig, echo_sync, busy, meas_done, timeout}
  } exp_t;

  exp_t sb[$];
  logic clk = 1'b0;
  logic rst_n;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   stim_done = 1'b0;
  logic p_busy = 1'b0;
  logic p_trig = 1'b0;
  logic p_es   = 1'b0;

  chao_trig_ctrl_if bus();

  chao_trig_ctrl #(
    .TRIG_CYCLES  (TRIG_C),
    .RISE_TIMEOUT (RISE_T),
    .ECHO_MAX     (ECHO_M),
    .PERIOD_CYCLES(PER),
    .CNT_W        (22)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_SNAP:   return "snap";
      K_BUSY_R: return "busy_rise";
      K_TRIG_R: return "trig_rise";
      K_TRIG_F: return "trig_fall";
      K_ES_R:   return "echo_sync_rise";
      K_ES_F:   return "echo_sync_fall";
      K_DONE:   return "meas_done";
      K_TOUT:   return "timeout";
      K_BUSY_F: return "busy_fall";
      default:  return "unknown";
    endcase
  endfunction

  // ---------------- monitor / checker ----------------
  task automatic obs(input int k);
    exp_t e;
    n_chk++;
    if (sb.size() == 0 || sb[0].kind == K_SNAP) begin
      $display("FAIL %s: unexpected event at cycle %0d, required none", kname(k), cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind == k && e.cyc == cyc) n_pass++;
      else $display("FAIL %s: got %s at cycle %0d, required %s at cycle %0d",
                    kname(e.kind), kname(k), cyc, kname(e.kind), e.cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] outs;
    outs = {bus.trig, bus.echo_sync, bus.busy, bus.meas_done, bus.timeout};
    while (sb.size() > 0 && sb[0].kind == K_SNAP && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc == cyc && outs === e.val) n_pass++;
      else $display("FAIL snap@%0d: outputs %b at cycle %0d, required %b", e.cyc, outs, cyc, e.val);
    end
    if (bus.busy === 1'b1 && !p_busy)      obs(K_BUSY_R);
    if (bus.trig === 1'b1 && !p_trig)      obs(K_TRIG_R);
    if (bus.trig !== 1'b1 && p_trig)       obs(K_TRIG_F);
    if (bus.echo_sync === 1'b1 && !p_es)   obs(K_ES_R);
    if (bus.echo_sync !== 1'b1 && p_es)    obs(K_ES_F);
    if (bus.meas_done !== 1'b0)            obs(K_DONE);
    if (bus.timeout !== 1'b0)              obs(K_TOUT);
    if (bus.busy !== 1'b1 && p_busy)       obs(K_BUSY_F);
    p_busy = (bus.busy === 1'b1);
    p_trig = (bus.trig === 1'b1);
    p_es   = (bus.echo_sync === 1'b1);
    if (cyc > LIMIT) begin
      n_chk++;
      $display("FAIL watchdog: stimulus still running at cycle %0d, required finish by %0d", cyc, LIMIT);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
    if (stim_done) begin
      n_chk++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL leftover: %0d expected items never seen (next %s@%0d), required 0",
                    sb.size(), kname(sb[0].kind), sb[0].cyc);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic ev(input int k, input int c);
    sb.push_back('{k, c, 5'b0});
  endtask

  task automatic snap(input int c, input logic [4:0] v);
    sb.push_back('{K_SNAP, c, v});
  endtask

  initial begin
    int t0;
    int c;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.echo   = 1'b0;

    // 1. reset and idle: nothing moves
    snap(3, 5'b00000);
    snap(203, 5'b00000);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(205);

    // 2. normal measurement, then a second (echo-less) one with enable dropped
    t0 = cyc + 1;
    ev(K_BUSY_R, t0); ev(K_TRIG_R, t0); snap(t0 + 2, 5'b10100);
    ev(K_TRIG_F, t0 + 4); ev(K_ES_R, t0 + 15); ev(K_ES_F, t0 + 45); ev(K_DONE, t0 + 46);
    ev(K_TRIG_R, t0 + 100); ev(K_TRIG_F, t0 + 104); ev(K_TOUT, t0 + 124); ev(K_BUSY_F, t0 + 200);
    bus.enable = 1'b1;
    wait_cyc(t0 + 13);  bus.echo = 1'b1;
    wait_cyc(t0 + 43);  bus.echo = 1'b0;
    wait_cyc(t0 + 101); bus.enable = 1'b0;
    wait_cyc(t0 + 205);

    // 3. no echo: rise timeout 20 cycles after WAIT_RISE entry
    t0 = cyc + 1;
    ev(K_BUSY_R, t0); ev(K_TRIG_R, t0); ev(K_TRIG_F, t0 + 4); ev(K_TOUT, t0 + 24);
    ev(K_TRIG_R, t0 + 100); ev(K_TRIG_F, t0 + 104); ev(K_TOUT, t0 + 124); ev(K_BUSY_F, t0 + 200);
    bus.enable = 1'b1;
    wait_cyc(t0 + 101); bus.enable = 1'b0;
    wait_cyc(t0 + 205);

    // 4. stuck echo: echo-high timeout 50 cycles after WAIT_FALL entry
    t0 = cyc + 1;
    ev(K_BUSY_R, t0); ev(K_TRIG_R, t0); ev(K_TRIG_F, t0 + 4); ev(K_ES_R, t0 + 15);
    snap(t0 + 40, 5'b01100); ev(K_TOUT, t0 + 66); ev(K_ES_F, t0 + 82);
    ev(K_TRIG_R, t0 + 100); ev(K_TRIG_F, t0 + 104); ev(K_TOUT, t0 + 124); ev(K_BUSY_F, t0 + 200);
    bus.enable = 1'b1;
    wait_cyc(t0 + 13);  bus.echo = 1'b1;
    wait_cyc(t0 + 80);  bus.echo = 1'b0;
    wait_cyc(t0 + 101); bus.enable = 1'b0;
    wait_cyc(t0 + 205);

    // 5a. stale echo: high before and through TRIG, must go low then high again
    c = cyc;
    ev(K_ES_R, c + 2);
    bus.echo = 1'b1;
    wait_cyc(c + 5);
    t0 = cyc + 1;
    ev(K_BUSY_R, t0); ev(K_TRIG_R, t0); ev(K_TRIG_F, t0 + 4); ev(K_ES_F, t0 + 10);
    ev(K_ES_R, t0 + 14); ev(K_ES_F, t0 + 24); ev(K_DONE, t0 + 25); ev(K_BUSY_F, t0 + 100);
    bus.enable = 1'b1;
    wait_cyc(t0 + 8);   bus.echo = 1'b0;
    wait_cyc(t0 + 12);  bus.echo = 1'b1;
    wait_cyc(t0 + 22);  bus.echo = 1'b0;
    wait_cyc(t0 + 30);  bus.enable = 1'b0;
    wait_cyc(t0 + 105);

    // 5b. 3-cycle echo glitch during TRIG is ignored
    t0 = cyc + 1;
    ev(K_BUSY_R, t0); ev(K_TRIG_R, t0); ev(K_ES_R, t0 + 2); ev(K_TRIG_F, t0 + 4);
    ev(K_ES_F, t0 + 5); ev(K_ES_R, t0 + 15); ev(K_ES_F, t0 + 35); ev(K_DONE, t0 + 36);
    ev(K_BUSY_F, t0 + 100);
    bus.enable = 1'b1;
    wait_cyc(t0);       bus.echo = 1'b1;
    wait_cyc(t0 + 3);   bus.echo = 1'b0;
    wait_cyc(t0 + 13);  bus.echo = 1'b1;
    wait_cyc(t0 + 33);  bus.echo = 1'b0;
    wait_cyc(t0 + 40);  bus.enable = 1'b0;
    wait_cyc(t0 + 105);

    // 6a. enable dropped in WAIT_FALL: measurement completes, then IDLE
    t0 = cyc + 1;
    ev(K_BUSY_R, t0); ev(K_TRIG_R, t0); ev(K_TRIG_F, t0 + 4); ev(K_ES_R, t0 + 15);
    ev(K_ES_F, t0 + 26); ev(K_DONE, t0 + 27); ev(K_BUSY_F, t0 + 100); snap(t0 + 110, 5'b00000);
    bus.enable = 1'b1;
    wait_cyc(t0 + 13);  bus.echo = 1'b1;
    wait_cyc(t0 + 19);  bus.enable = 1'b0;
    wait_cyc(t0 + 24);  bus.echo = 1'b0;
    wait_cyc(t0 + 112);

    // 6b. reset mid-TRIG: trig and busy drop on the next edge, no pulses
    t0 = cyc + 1;
    ev(K_BUSY_R, t0); ev(K_TRIG_R, t0); ev(K_TRIG_F, t0 + 2); ev(K_BUSY_F, t0 + 2);
    snap(t0 + 20, 5'b00000);
    bus.enable = 1'b1;
    wait_cyc(t0 + 1);   rst_n = 1'b0; bus.enable = 1'b0;
    wait_cyc(t0 + 4);   rst_n = 1'b1;
    wait_cyc(t0 + 22);
    stim_done = 1'b1;
  end
endmodule
